// File: rtl/snax_cgra_csr_manager.sv
// snax_cgra_csr_manager: stages core CSR writes and commits them to the CGRA config port on launch
module snax_cgra_csr_manager #(
    parameter int unsigned NumRwCsr     = 1,
    parameter int unsigned NumRoCsr     = 4,
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned RegDataWidth = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [RegAddrWidth-1:0]          csr_req_addr_i,
    input  logic [RegDataWidth-1:0]          csr_req_data_i,
    input  logic                             csr_req_write_i,
    input  logic                             csr_req_valid_i,
    output logic                             csr_req_ready_o,
    output logic [RegDataWidth-1:0]          csr_rsp_data_o,
    output logic                             csr_rsp_valid_o,
    input  logic                             csr_rsp_ready_i,
    output logic [NumRwCsr*RegDataWidth-1:0] csr_reg_set_o,
    output logic                             csr_reg_set_valid_o,
    input  logic                             csr_reg_set_ready_i,
    input  logic [NumRoCsr*RegDataWidth-1:0] csr_reg_ro_set_i,
    output logic                             busy_o
);
    localparam logic [RegAddrWidth-1:0] LaunchIdx = RegAddrWidth'(NumRwCsr);
    localparam logic [RegAddrWidth-1:0] CntIdx    = RegAddrWidth'(NumRwCsr + NumRoCsr + 1);

    typedef enum logic {Idle, Commit} state_e;

    state_e                                 state_q, state_d;
    logic [NumRwCsr-1:0][RegDataWidth-1:0]  stage_q, stage_d;
    logic [RegDataWidth-1:0]                cnt_q, cnt_d;
    logic                                   rsp_valid_q, rsp_valid_d;
    logic [RegDataWidth-1:0]                rsp_data_q, rsp_data_d, rd_data;
    logic                                   is_rw, is_launch, rd_fire, wr_fire, launch, handshake;

    assign is_rw     = csr_req_addr_i < RegAddrWidth'(NumRwCsr);
    assign is_launch = csr_req_addr_i == LaunchIdx;
    // Staging and launch writes stall while a commit holds the staging set stable
    assign csr_req_ready_o = csr_req_write_i ? !(state_q == Commit && (is_rw || is_launch))
                                             : (!rsp_valid_q || csr_rsp_ready_i);
    assign rd_fire   = csr_req_valid_i && csr_req_ready_o && !csr_req_write_i;
    assign wr_fire   = csr_req_valid_i && csr_req_ready_o && csr_req_write_i;
    assign launch    = wr_fire && is_launch && csr_req_data_i[0];
    assign handshake = csr_reg_set_valid_o && csr_reg_set_ready_i;

    assign csr_reg_set_o   = stage_q;
    assign csr_rsp_data_o  = rsp_data_q;
    assign csr_rsp_valid_o = rsp_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= Idle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == Idle ? (launch ? Commit : Idle) : (handshake ? Idle : Commit);
    end

    always_comb begin
        csr_reg_set_valid_o = state_q == Commit;
        busy_o              = state_q == Commit;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NumRwCsr; i++)
            if (csr_req_addr_i == RegAddrWidth'(i)) rd_data = stage_q[i];
        if (is_launch) rd_data = RegDataWidth'(busy_o);
        for (int i = 0; i < NumRoCsr; i++)
            if (csr_req_addr_i == RegAddrWidth'(NumRwCsr + 1 + i))
                rd_data = csr_reg_ro_set_i[i*RegDataWidth +: RegDataWidth];
        if (csr_req_addr_i == CntIdx) rd_data = cnt_q;
    end

    always_comb begin
        stage_d = stage_q;
        for (int i = 0; i < NumRwCsr; i++)
            if (wr_fire && csr_req_addr_i == RegAddrWidth'(i)) stage_d[i] = csr_req_data_i;
        cnt_d       = handshake ? cnt_q + 1'b1 : cnt_q;
        rsp_valid_d = rd_fire || (rsp_valid_q && !csr_rsp_ready_i);
        rsp_data_d  = rd_fire ? rd_data : rsp_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_snax_cgra_csr_manager.sv
// tb_snax_cgra_csr_manager: directed plus randomized checks against a cycle-level reference model
module tb_snax_cgra_csr_manager;
    localparam int NRW = 1;
    localparam int NRO = 4;
    localparam int L   = NRW;
    localparam int CNT = L + NRO + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       req_addr, req_data;
    logic              req_write, req_valid, req_ready;
    logic [31:0]       rsp_data;
    logic              rsp_valid, rsp_ready;
    logic [NRW*32-1:0] set_o;
    logic              set_valid, set_ready;
    logic [NRO*32-1:0] ro;
    logic              busy;

    int checks = 0, errors = 0, vhigh = 0;

    logic [31:0] m_stage [NRW];
    logic [31:0] m_cnt, m_rd;
    bit          m_commit, m_rv;

    snax_cgra_csr_manager #(.NumRwCsr(NRW), .NumRoCsr(NRO)) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_req_addr_i(req_addr), .csr_req_data_i(req_data),
        .csr_req_write_i(req_write), .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
        .csr_rsp_data_o(rsp_data), .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
        .csr_reg_set_o(set_o), .csr_reg_set_valid_o(set_valid), .csr_reg_set_ready_i(set_ready),
        .csr_reg_ro_set_i(ro), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic m_ready();
        return req_write ? !(m_commit && (req_addr < NRW || req_addr == L)) : (!m_rv || rsp_ready);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < NRW) return m_stage[int'(a)];
        if (a == L) return {31'b0, m_commit};
        if (a > L && a <= L + NRO) return ro[(int'(a) - L - 1)*32 +: 32];
        if (a == CNT) return m_cnt;
        return 32'h0;
    endfunction

    task automatic compare();
        logic [NRW*32-1:0] mset;
        for (int i = 0; i < NRW; i++) mset[i*32 +: 32] = m_stage[i];
        chk("req_ready", req_ready, m_ready());
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_data", rsp_data, m_rd);
        chk("set_valid", set_valid, m_commit);
        chk("busy", busy, m_commit);
        chk("set_o", set_o, mset);
        if (set_valid) vhigh++;
    endtask

    task automatic update();
        bit acc, hs;
        if (rst) begin
            for (int i = 0; i < NRW; i++) m_stage[i] = 0;
            m_cnt = 0; m_rd = 0; m_rv = 0; m_commit = 0;
            return;
        end
        acc = req_valid && m_ready();
        hs  = m_commit && set_ready;
        if (acc && !req_write) begin
            m_rv = 1; m_rd = m_read(req_addr);
        end else if (rsp_ready) m_rv = 0;
        if (acc && req_write && req_addr < NRW) m_stage[int'(req_addr)] = req_data;
        if (acc && req_write && req_addr == L && req_data[0]) m_commit = 1;
        if (hs) begin
            m_commit = 0; m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        update();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        req_valid = 1; req_write = 1; req_addr = a; req_data = d;
        tick();
        req_valid = 0;
    endtask

    task automatic rd(input int a);
        req_valid = 1; req_write = 0; req_addr = a;
        tick();
        req_valid = 0;
    endtask

    initial begin
        int v0;
        rst = 1; req_addr = 0; req_data = 0; req_write = 0; req_valid = 0;
        rsp_ready = 1; set_ready = 0; ro = '0;
        for (int i = 0; i < NRW; i++) m_stage[i] = 0;
        m_cnt = 0; m_rd = 0; m_rv = 0; m_commit = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;

        // Commit with accelerator holding off for three cycles
        wr(0, 32'hDEADBEEF);
        v0 = vhigh;
        wr(L, 1);
        req_valid = 1; req_write = 1; req_addr = 0; req_data = 32'h1234;
        repeat (3) tick();
        set_ready = 1;
        tick();
        chk("stall_end", req_ready, 1'b1);
        tick();
        req_valid = 0;
        tick();
        chk("valid_len", vhigh - v0, 4);

        // Back-to-back RO reads
        ro = {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 1; i <= NRO; i++) begin
            rd(L + i);
            chk("ro_rd", rsp_data, i);
        end
        tick();

        // Response back-pressure
        rsp_ready = 0;
        rd(L + 1);
        req_valid = 1; req_write = 0; req_addr = L + 2;
        tick(); tick();
        chk("held", rsp_data, 1);
        rsp_ready = 1;
        tick();
        req_valid = 0;
        chk("second", rsp_data, 2);
        tick();

        // Commit counting and busy readback
        rst = 1; tick(); rst = 0;
        repeat (3) begin wr(L, 1); tick(); end
        rd(CNT);
        chk("cnt3", rsp_data, 3);
        wr(L, 1);
        rd(L);
        chk("busy_rd1", rsp_data, 1);
        rd(L);
        chk("busy_rd0", rsp_data, 0);
        wr(L, 1);
        rd(CNT);
        chk("cnt_old", rsp_data, 4);
        rd(CNT);
        chk("cnt_new", rsp_data, 5);

        // Launch with bit 0 clear does nothing
        wr(L, 2);
        chk("nolaunch", set_valid, 1'b0);
        tick();

        // Counter wrap
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        wr(L, 1); tick();
        rd(CNT);
        chk("wrap", rsp_data, 0);

        // Reset in the middle of a commit
        set_ready = 0;
        wr(0, 5);
        wr(L, 1);
        rsp_ready = 0;
        rd(CNT);
        rst = 1; tick(); rst = 0;
        rsp_ready = 1;
        chk("rst_valid", set_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp", rsp_valid, 1'b0);
        rd(0);
        chk("rst_stage", rsp_data, 0);

        // Unmapped index
        wr(0, 7);
        wr(32'h40, 32'hFFFF_FFFF);
        rd(32'h40);
        chk("unmapped", rsp_data, 0);
        rd(0);
        chk("stage_kept", rsp_data, 7);
        set_ready = 1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = $urandom_range(0, 2) != 0;
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = ($urandom_range(0, 15) == 0) ? 32'h40 : $urandom_range(0, CNT + 1);
            req_data  = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
            rsp_ready = $urandom_range(0, 3) != 0;
            set_ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 7) == 0) ro = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
